// File: rtl/cpu_status_pkg.sv
// Shared definitions for the 6502 processor status register: flag positions,
// ALU-flag update selectors, direct flag commands and branch condition fields.
package cpu_status_pkg;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_I = 2;
  localparam int unsigned FLAG_D = 3;
  localparam int unsigned FLAG_B = 4;
  localparam int unsigned FLAG_5 = 5;
  localparam int unsigned FLAG_V = 6;
  localparam int unsigned FLAG_N = 7;

  typedef enum logic [2:0] {
    UPD_NONE   = 3'd0,
    UPD_NZ     = 3'd1,
    UPD_NZC    = 3'd2,
    UPD_NZCV   = 3'd3,
    UPD_Z_BIT  = 3'd4,
    UPD_C_ONLY = 3'd5
  } upd_sel_e;

  typedef enum logic [2:0] {
    FOP_NONE = 3'd0,
    FOP_SEC  = 3'd1,
    FOP_CLC  = 3'd2,
    FOP_SEI  = 3'd3,
    FOP_CLI  = 3'd4,
    FOP_SED  = 3'd5,
    FOP_CLD  = 3'd6,
    FOP_CLV  = 3'd7
  } flag_op_e;

  // cond = opcode[7:5]: [2:1] picks the flag, [0] is the value that takes the branch
  localparam int unsigned COND_VAL_BIT = 0;
  localparam int unsigned COND_SEL_LSB = 1;
  localparam int unsigned COND_SEL_MSB = 2;

  typedef enum logic [1:0] {
    CSEL_N = 2'b00,
    CSEL_V = 2'b01,
    CSEL_C = 2'b10,
    CSEL_Z = 2'b11
  } cond_sel_e;

  function automatic logic [7:0] push_image(input logic [7:0] p, input logic brk);
    logic [7:0] img;
    img         = p;
    img[FLAG_5] = 1'b1;
    img[FLAG_B] = brk;
    return img;
  endfunction

endpackage

// File: rtl/cpu_status_reg_if.sv
// Status-register bus: flag sources and commands from the sequencer/ALU,
// and the status outputs consumed by the ALU, stack push path and branch logic.
interface cpu_status_reg_if;
  logic [2:0] upd_sel;
  logic       alu_CO;
  logic       alu_V;
  logic       alu_Z;
  logic       alu_N;
  logic [7:0] DB;
  logic [2:0] flag_op;
  logic       load_p;
  logic       irq_entry;
  logic       push_brk;
  logic       fetch;
  logic [2:0] cond;
  logic [7:0] P;
  logic [7:0] p_push;
  logic       C;
  logic       D;
  logic       irq_mask;
  logic       branch_taken;

  modport master (
    output upd_sel, alu_CO, alu_V, alu_Z, alu_N, DB, flag_op, load_p,
           irq_entry, push_brk, fetch, cond,
    input  P, p_push, C, D, irq_mask, branch_taken
  );

  modport slave (
    input  upd_sel, alu_CO, alu_V, alu_Z, alu_N, DB, flag_op, load_p,
           irq_entry, push_brk, fetch, cond,
    output P, p_push, C, D, irq_mask, branch_taken
  );
endinterface

// File: rtl/status_branch_eval.sv
// Combinational 6502 branch condition: compares the selected flag of P with cond[0].
module status_branch_eval
  import cpu_status_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [7:0] p,
  output logic       taken
);

  logic flag;

  always_comb begin
    flag = 1'b0;
    case (cond_sel_e'(cond[COND_SEL_MSB:COND_SEL_LSB]))
      CSEL_N:  flag = p[FLAG_N];
      CSEL_V:  flag = p[FLAG_V];
      CSEL_C:  flag = p[FLAG_C];
      CSEL_Z:  flag = p[FLAG_Z];
      default: flag = 1'b0;
    endcase
    taken = (flag == cond[COND_VAL_BIT]);
  end

endmodule

// File: rtl/cpu_status_reg.sv
// 6502 processor status register with delayed ALU-flag capture, direct flag
// commands, PLP/RTI load, push image, branch evaluation and boundary-delayed IRQ mask.
module cpu_status_reg
  import cpu_status_pkg::*;
#(
  parameter logic [7:0] RESET_P    = 8'h34,
  parameter bit         BIT5_FORCE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RDY,
  cpu_status_reg_if.slave   bus
);

  logic [7:0] p_q;
  logic [7:0] p_next;
  upd_sel_e   pend_q;
  upd_sel_e   pend_next;
  logic [1:0] pend_db_q;
  logic       irq_mask_q;
  logic [7:0] p_out;

  always_comb begin
    pend_next = UPD_NONE;
    case (bus.upd_sel)
      UPD_NZ, UPD_NZC, UPD_NZCV, UPD_Z_BIT, UPD_C_ONLY: pend_next = upd_sel_e'(bus.upd_sel);
      default:                                          pend_next = UPD_NONE;
    endcase
  end

  // Writes are layered so later sources override earlier ones on shared bits.
  always_comb begin
    p_next = p_q;
    case (pend_q)
      UPD_NZ: begin
        p_next[FLAG_N] = bus.alu_N;
        p_next[FLAG_Z] = bus.alu_Z;
      end
      UPD_NZC: begin
        p_next[FLAG_N] = bus.alu_N;
        p_next[FLAG_Z] = bus.alu_Z;
        p_next[FLAG_C] = bus.alu_CO;
      end
      UPD_NZCV: begin
        p_next[FLAG_N] = bus.alu_N;
        p_next[FLAG_Z] = bus.alu_Z;
        p_next[FLAG_C] = bus.alu_CO;
        p_next[FLAG_V] = bus.alu_V;
      end
      UPD_Z_BIT: begin
        p_next[FLAG_Z] = bus.alu_Z;
        p_next[FLAG_N] = pend_db_q[1];
        p_next[FLAG_V] = pend_db_q[0];
      end
      UPD_C_ONLY: p_next[FLAG_C] = bus.alu_CO;
      default: ;
    endcase

    if (bus.load_p) p_next = bus.DB;

    case (flag_op_e'(bus.flag_op))
      FOP_SEC: p_next[FLAG_C] = 1'b1;
      FOP_CLC: p_next[FLAG_C] = 1'b0;
      FOP_SEI: p_next[FLAG_I] = 1'b1;
      FOP_CLI: p_next[FLAG_I] = 1'b0;
      FOP_SED: p_next[FLAG_D] = 1'b1;
      FOP_CLD: p_next[FLAG_D] = 1'b0;
      FOP_CLV: p_next[FLAG_V] = 1'b0;
      default: ;
    endcase

    if (bus.irq_entry) p_next[FLAG_I] = 1'b1;
    if (BIT5_FORCE)    p_next[FLAG_5] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q        <= RESET_P;
      pend_q     <= UPD_NONE;
      pend_db_q  <= '0;
      irq_mask_q <= 1'b1;
    end else if (RDY) begin
      p_q       <= p_next;
      pend_q    <= pend_next;
      pend_db_q <= bus.DB[7:6];
      if (bus.fetch) irq_mask_q <= p_q[FLAG_I];
    end
  end

  always_comb begin
    p_out = p_q;
    if (BIT5_FORCE) p_out[FLAG_5] = 1'b1;
  end

  assign bus.P        = p_out;
  assign bus.p_push   = push_image(p_out, bus.push_brk);
  assign bus.C        = p_out[FLAG_C];
  assign bus.D        = p_out[FLAG_D];
  assign bus.irq_mask = irq_mask_q;

  status_branch_eval u_branch (
    .cond  (bus.cond),
    .p     (p_out),
    .taken (bus.branch_taken)
  );

endmodule

// File: tb/tb_cpu_status_reg.sv
// Directed plus randomized check of cpu_status_reg against a flag-level reference model.
module tb_cpu_status_reg;

  logic clk = 1'b0;
  logic reset;
  logic rdy;

  cpu_status_reg_if bus ();

  cpu_status_reg #(
    .RESET_P    (8'h34),
    .BIT5_FORCE (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .RDY   (rdy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model: individual flags, pending ALU request, IRQ mask
  bit mn, mv, mb, md, mi, mz, mc;
  bit m_mask;
  int m_pend;
  bit [1:0] m_pdb;

  function automatic logic [7:0] model_p();
    return {mn, mv, 1'b1, mb, md, mi, mz, mc};
  endfunction

  function automatic logic model_branch(input logic [2:0] cd);
    case (cd)
      3'd0: return !mn;   // BPL
      3'd1: return mn;    // BMI
      3'd2: return !mv;   // BVC
      3'd3: return mv;    // BVS
      3'd4: return !mc;   // BCC
      3'd5: return mc;    // BCS
      3'd6: return !mz;   // BNE
      default: return mz; // BEQ
    endcase
  endfunction

  task automatic model_edge();
    bit old_i;
    if (reset) begin
      {mn, mv, mb, md, mi, mz, mc} = 7'b0010100;
      m_pend = 0;
      m_mask = 1'b1;
    end else if (rdy) begin
      old_i = mi;
      if (m_pend inside {1, 2, 3, 4}) mz = bus.alu_Z;
      if (m_pend inside {1, 2, 3})    mn = bus.alu_N;
      if (m_pend inside {2, 3, 5})    mc = bus.alu_CO;
      if (m_pend == 3)                mv = bus.alu_V;
      if (m_pend == 4)                {mn, mv} = m_pdb;
      if (bus.load_p) {mn, mv, mb, md, mi, mz, mc} = {bus.DB[7:6], bus.DB[4:0]};
      case (bus.flag_op)
        3'd1: mc = 1'b1;
        3'd2: mc = 1'b0;
        3'd3: mi = 1'b1;
        3'd4: mi = 1'b0;
        3'd5: md = 1'b1;
        3'd6: md = 1'b0;
        3'd7: mv = 1'b0;
        default: ;
      endcase
      if (bus.irq_entry) mi = 1'b1;
      if (bus.fetch) m_mask = old_i;
      m_pend = (bus.upd_sel <= 3'd5) ? int'(bus.upd_sel) : 0;
      m_pdb  = bus.DB[7:6];
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("P", bus.P, model_p());
    check("p_push", bus.p_push, {mn, mv, 1'b1, bus.push_brk, md, mi, mz, mc});
    check("C", {7'd0, bus.C}, {7'd0, mc});
    check("D", {7'd0, bus.D}, {7'd0, md});
    check("irq_mask", {7'd0, bus.irq_mask}, {7'd0, m_mask});
    check("branch", {7'd0, bus.branch_taken}, {7'd0, model_branch(bus.cond)});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    reset         = 1'b0;
    rdy           = 1'b1;
    bus.upd_sel   = '0;
    bus.alu_CO    = 1'b0;
    bus.alu_V     = 1'b0;
    bus.alu_Z     = 1'b0;
    bus.alu_N     = 1'b0;
    bus.DB        = '0;
    bus.flag_op   = '0;
    bus.load_p    = 1'b0;
    bus.irq_entry = 1'b0;
    bus.push_brk  = 1'b0;
    bus.fetch     = 1'b0;
    bus.cond      = '0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();

    // Load all ones, then reset
    idle(); bus.load_p = 1'b1; bus.DB = 8'hFF; tick();
    check("load_ff", bus.P, 8'hFF);
    idle(); reset = 1'b1; bus.cond = 3'b101; tick();
    check("reset_p", bus.P, 8'h34);
    check("reset_mask", {7'd0, bus.irq_mask}, 8'd1);
    check("reset_bcs", {7'd0, bus.branch_taken}, 8'd0);

    // NZCV issued, flags presented one cycle later
    idle(); bus.upd_sel = 3'd3; tick();
    check("nzcv_early", bus.P, 8'h34);
    idle(); bus.alu_CO = 1'b1; bus.alu_V = 1'b1; bus.alu_N = 1'b1; tick();
    check("nzcv_late", bus.P, 8'hF5);

    // Z_BIT uses DB[7:6] captured at issue, not at apply
    idle(); reset = 1'b1; tick();
    idle(); bus.upd_sel = 3'd4; bus.DB = 8'h80; tick();
    idle(); bus.DB = 8'h40; bus.alu_Z = 1'b1; bus.alu_V = 1'b1; tick();
    check("z_bit", bus.P, 8'hB6);

    // Back-to-back NZ then C_ONLY
    idle(); bus.load_p = 1'b1; bus.upd_sel = 3'd1; tick();
    idle(); bus.upd_sel = 3'd5; bus.alu_N = 1'b1; tick();
    idle(); bus.alu_CO = 1'b1; bus.alu_Z = 1'b1; tick();
    check("b2b", bus.P, 8'hA1);

    // Pending NZC sets C, same-edge CLC wins
    idle(); bus.upd_sel = 3'd2; tick();
    idle(); bus.alu_CO = 1'b1; bus.flag_op = 3'd2; tick();
    check("clc_wins", bus.P, 8'h20);

    // CLI takes effect on irq_mask one boundary late
    idle(); bus.flag_op = 3'd3; bus.fetch = 1'b1; tick();
    idle(); bus.fetch = 1'b1; tick();
    check("mask_set", {7'd0, bus.irq_mask}, 8'd1);
    idle(); bus.flag_op = 3'd4; bus.fetch = 1'b1; tick();
    check("cli_edge_mask", {7'd0, bus.irq_mask}, 8'd1);
    idle(); bus.fetch = 1'b1; tick();
    check("cli_next_mask", {7'd0, bus.irq_mask}, 8'd0);

    // Load zero, then stall with SEC pending on the inputs
    idle(); bus.load_p = 1'b1; bus.DB = 8'h00; tick();
    check("load_zero", bus.P, 8'h20);
    for (int i = 0; i < 3; i++) begin
      idle(); rdy = 1'b0; bus.flag_op = 3'd1; bus.upd_sel = 3'd2; bus.alu_CO = 1'b1; tick();
      check("stall_hold", bus.P, 8'h20);
    end
    bus.push_brk = 1'b1; #1;
    check("push_brk", bus.p_push, 8'h30);

    // Reset overrides a stall
    idle(); rdy = 1'b0; reset = 1'b1; tick();
    check("reset_stall", bus.P, 8'h34);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset         = ($urandom_range(63) == 0);
      rdy           = ($urandom_range(3) != 0);
      bus.upd_sel   = 3'($urandom_range(7));
      bus.alu_CO    = 1'($urandom_range(1));
      bus.alu_V     = 1'($urandom_range(1));
      bus.alu_Z     = 1'($urandom_range(1));
      bus.alu_N     = 1'($urandom_range(1));
      bus.DB        = 8'($urandom_range(255));
      bus.flag_op   = ($urandom_range(1) == 0) ? 3'd0 : 3'($urandom_range(7));
      bus.load_p    = ($urandom_range(7) == 0);
      bus.irq_entry = ($urandom_range(7) == 0);
      bus.push_brk  = 1'($urandom_range(1));
      bus.fetch     = 1'($urandom_range(1));
      bus.cond      = 3'($urandom_range(7));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/cpu_status_reg.md
Name: cpu_status_reg

Overview:
- Processor status register (P) for the 6502 core.
- Consumes the registered flag outputs of the ALU (CO, V, Z, N), data-bus values for PLP/RTI/BIT, and direct flag commands (SEC/CLC/SEI/CLI/SED/CLD/CLV, interrupt entry).
- Supplies C and D back to the ALU (CI, BCD), the push image for PHP/BRK/IRQ, the branch-condition result, and the instruction-boundary-delayed IRQ mask.

Parameters:
- RESET_P, 8'h34, value of P after reset (I=1, B=1, bit5=1, all others 0).
- BIT5_FORCE, 1, when 1, bit 5 of P always reads 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- RDY  in  1  global stall; when 0, all state holds
- upd_sel  in  3  ALU-flag update request for the ALU op issued this cycle (encodings in package)
- alu_CO  in  1  ALU carry out (registered in ALU, valid the cycle after issue)
- alu_V  in  1  ALU overflow
- alu_Z  in  1  ALU zero
- alu_N  in  1  ALU negative
- DB  in  8  data bus, used by PLP/RTI load and BIT N/V
- flag_op  in  3  direct flag command (NONE, SEC, CLC, SEI, CLI, SED, CLD, CLV)
- load_p  in  1  load P from DB (PLP/RTI)
- irq_entry  in  1  set I (BRK/IRQ/NMI vector fetch)
- push_brk  in  1  selects B bit value in p_push
- fetch  in  1  instruction boundary (opcode fetch cycle)
- cond  in  3  branch condition, opcode bits [7:5]
- P  out  8  current status {N,V,1,B,D,I,Z,C}
- p_push  out  8  push image: P with bit5=1, B=push_brk
- C  out  1  carry to ALU CI
- D  out  1  decimal mode to ALU BCD
- irq_mask  out  1  I flag as of the last instruction boundary
- branch_taken  out  1  combinational result of cond against current P

Behaviour:
- Reset (reset=1 at posedge clk): P=RESET_P; pending update cleared; irq_mask=1. Reset overrides RDY and any in-flight update.
- upd_sel encodings: NONE, NZ, NZC, NZCV, Z_BIT (Z from ALU, N=DB[7], V=DB[6]), C_ONLY.
- Flag latency:
  - ALU flags are registered, so an update requested in cycle t with RDY=1 is captured into a pending register (sel plus, for Z_BIT, DB[7:6]).
  - The pending update is applied at the next RDY=1 edge, using alu_* as presented then.
  - Net latency: P reflects the flags 2 edges after issue.
- Back-to-back requests: in the same edge, the pending update is applied and the new request becomes pending. No request is lost.
- Priority within one edge, highest last (later overrides the same bits): pending ALU update, load_p, flag_op, irq_entry.
- load_p: P = DB, except bit5 forced per BIT5_FORCE; B stored as DB[4].
- RDY=0: P, the pending register and irq_mask hold. Inputs are ignored.
- irq_mask: updated to I on a fetch=1, RDY=1 edge, using the I value before that edge's writes. This reproduces the one-instruction CLI/SEI/PLP delay.
- branch_taken, with cond[2:1] selecting the flag (00 N, 01 V, 10 C, 11 Z) and cond[0] the required value: taken = (flag == cond[0]). Evaluated on P only; pending updates are not forwarded.
- C and D are driven straight from P with no forwarding; the sequencer spaces dependent ops.
- Invalid upd_sel or flag_op codes are treated as NONE.

Decomposition:
- Package cpu_status_pkg holds:
  - flag bit indices (FLAG_C=0, FLAG_Z=1, FLAG_I=2, FLAG_D=3, FLAG_B=4, FLAG_V=6, FLAG_N=7);
  - upd_sel encodings;
  - flag_op encodings;
  - cond field positions.
- One sub-module, status_branch_eval: combinational cond/P to branch_taken, reused by the branch-target sequencer.

Test Plan:
- Reset with P=8'hFF, then reset=1 for one cycle -> P=8'h34, irq_mask=1, branch_taken for cond=3'b101 (BCS) is 0.
- upd_sel=NZCV at t; alu_CO=1, V=1, Z=0, N=1 at t+1 -> P bits read N=1, V=1, Z=0, C=1 after the t+1 edge, and not earlier.
- Back-to-back NZ then C_ONLY with alu flags (N=1, Z=0) then (CO=1) -> final P has N=1, Z=0, C=1.
- Same edge: pending NZC sets C=1 while flag_op=CLC -> C=0 (direct command wins).
- CLI with I=1, then fetch -> irq_mask stays 1 on the CLI edge and becomes 0 only at the following fetch edge.
- load_p with DB=8'h00, then RDY=0 for 3 cycles with flag_op=SEC -> P=8'h20 (bit5 forced) and unchanged while stalled. p_push with push_brk=1 gives 8'h30.
